fifo_wr_ctrl: RTL
=================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, meaning log2 of FIFO depth (depth = 16).
REQ-002 SHALL have parameter AFULL_THRESH, default 12, meaning fill level at or above which wafull asserts (1..2^ADDRSIZE).
REQ-003 SHALL have port clk  input  1  write-domain clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port winc  input  1  write request from producer.
REQ-006 SHALL have port rptr_gray  input  ADDRSIZE+1  Gray read pointer from read domain, asynchronous to clk.
REQ-007 SHALL have port wen  output  1  memory write enable.
REQ-008 SHALL have port waddr  output  ADDRSIZE  memory write address.
REQ-009 SHALL have port wptr_gray  output  ADDRSIZE+1  registered Gray write pointer, sent to read domain.
REQ-010 SHALL have port wfull  output  1  registered full flag.
REQ-011 SHALL have port wafull  output  1  registered almost-full flag.
REQ-012 SHALL have port wlevel  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
REQ-013 SHALL have port wovf_clr  input  1  clears sticky overflow.
REQ-014 SHALL have port wovf  output  1  sticky overflow flag.

Function
REQ-015 SHALL synchronize rptr_gray through two cascaded flop stages (rq1, rq2) clocked by clk; no logic between stages.
REQ-016 SHALL hold binary pointer wbin (ADDRSIZE+1 bits); accept a write when winc=1 and wfull=0.
REQ-017 SHALL drive wen = winc & ~wfull combinationally; waddr = wbin[ADDRSIZE-1:0].
REQ-018 SHALL compute wbin_next = wbin + accept, modulo 2^(ADDRSIZE+1), so pointer wrap is natural.
REQ-019 SHALL register wptr_gray <= (wbin_next >> 1) ^ wbin_next; only one bit changes per write.
REQ-020 SHALL register wfull <= 1 iff gray(wbin_next) == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}.
REQ-021 SHALL register wlevel <= wbin_next - gray2bin(rq2), modulo 2^(ADDRSIZE+1).
REQ-022 SHALL register wafull <= (level computed per REQ-021) >= AFULL_THRESH.
REQ-023 SHALL set wovf when winc=1 and wfull=1; hold until wovf_clr=1; set wins over simultaneous clear.
REQ-024 SHALL keep wbin and all memory outputs unchanged on a rejected (full) write.
REQ-025 SHALL treat wfull, wafull and wlevel as pessimistic: read progress appears after 2-3 clk cycles; full and level never under-report.
REQ-026 SHALL deassert wfull on the first clk edge at which rq2 reflects a read advance.

Reset
REQ-027 SHALL on rst=0 immediately clear wbin, wptr_gray, rq1, rq2, wlevel, wovf, wfull, wafull to 0.
REQ-028 SHALL tolerate rst mid-burst: the pending write is dropped and the next accepted write after release uses waddr=0.
REQ-029 SHALL require the read domain to be reset at the same time; no independent-reset recovery.

Structure
REQ-030 SHALL share the Gray/binary conversion functions and the ADDRSIZE default through the FIFO common package, also used by the read-side controller.
REQ-031 SHALL instantiate one sub-module, gray2bin (combinational, width ADDRSIZE+1), for rq2 conversion.
REQ-032 SHALL keep memory array and read-side logic outside this block.

Verification
REQ-033 SHALL verify reset: hold rst=0 with winc=1 -> wen=0, waddr=0, wptr_gray=0, flags 0, wlevel=0.
REQ-034 SHALL verify fill: rptr_gray=0, 16 consecutive winc -> waddr 0..15, wafull=1 after 12th write, wfull=1 after 16th, wlevel=16, wptr_gray=5'b11000.
REQ-035 SHALL verify overflow: full, winc 1 cycle -> wen=0, wbin unchanged, wovf=1; pulse wovf_clr -> wovf=0.
REQ-036 SHALL verify drain release: full, rptr_gray changes 0->1 -> wfull falls 2-3 clk edges later, wlevel=15.
REQ-037 SHALL verify wrap: 40 writes with reads keeping level <8 -> waddr wraps 15->0, wptr_gray changes one bit per write, wfull never set.
REQ-038 SHALL verify async reset mid-burst: rst=0 between edges during writes -> outputs clear before next edge; first post-reset write waddr=0.

Source files
------------

// File: rtl/fifo_wr_ctrl_pkg.sv
// fifo_wr_ctrl_pkg: FIFO common package shared by the write- and read-side pointer controllers.
//   DEF_ADDRSIZE   default log2 FIFO depth
//   ptr_t          widest pointer the helpers handle; callers size-cast to their own width
//   bin2gray()     binary -> Gray
//   gray2bin()     Gray -> binary (zero-extended inputs convert correctly in the low bits)
package fifo_wr_ctrl_pkg;

    localparam int DEF_ADDRSIZE = 4;
    localparam int PTR_MAXW = 32;

    typedef logic [PTR_MAXW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: producer/read-domain facing signals of the FIFO write controller.
//   winc       write request from producer
//   rptr_gray  Gray read pointer from the read domain (asynchronous)
//   wovf_clr   clears the sticky overflow flag
//   wen/waddr  memory write enable and address
//   wptr_gray  registered Gray write pointer to the read domain
//   wfull/wafull/wlevel  registered full, almost-full and fill level
//   wovf       sticky overflow flag
interface fifo_wr_ctrl_if import fifo_wr_ctrl_pkg::*; #(
    parameter int ADDRSIZE = DEF_ADDRSIZE
) ();

    logic                winc;
    logic [ADDRSIZE:0]   rptr_gray;
    logic                wovf_clr;
    logic                wen;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr_gray;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    modport master (
        output winc, rptr_gray, wovf_clr,
        input  wen, waddr, wptr_gray, wfull, wafull, wlevel, wovf
    );

    modport slave (
        input  winc, rptr_gray, wovf_clr,
        output wen, waddr, wptr_gray, wfull, wafull, wlevel, wovf
    );

endinterface

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// fifo_wr_ctrl_gray2bin: combinational Gray to binary converter of width W.
//   gray  Gray-coded input
//   bin   binary output
module fifo_wr_ctrl_gray2bin import fifo_wr_ctrl_pkg::*; #(
    parameter int W = DEF_ADDRSIZE + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(ptr_t'(gray)));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer/flag controller of an asynchronous FIFO.
//   clk   write-domain clock
//   rst   asynchronous active-low reset
//   bus   fifo_wr_ctrl_if.slave: winc, rptr_gray, wovf_clr in; wen, waddr,
//         wptr_gray, wfull, wafull, wlevel, wovf out
module fifo_wr_ctrl import fifo_wr_ctrl_pkg::*; #(
    parameter int ADDRSIZE     = DEF_ADDRSIZE,
    parameter int AFULL_THRESH = 12
) (
    input logic           clk,
    input logic           rst,
    fifo_wr_ctrl_if.slave bus
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AF_LVL = PW'(AFULL_THRESH);

    logic [ADDRSIZE:0] rq1, rq2, rbin;
    logic [ADDRSIZE:0] wbin, wbin_next, wgray_next, full_cmp, level_next;
    logic [ADDRSIZE:0] wptr_gray_q, wlevel_q;
    logic              wfull_q, wafull_q, wovf_q, accept;

    fifo_wr_ctrl_gray2bin #(.W(PW)) u_rq2_bin (
        .gray (rq2),
        .bin  (rbin)
    );

    // wen is also held low while reset is asserted so nothing reaches the memory
    assign accept     = bus.winc & ~wfull_q & rst;
    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = PW'(bin2gray(ptr_t'(wbin_next)));
    // full: write pointer one lap ahead of the synchronized read pointer
    assign full_cmp   = {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]};
    // rq2 lags the true read pointer, so the level can only over-report
    assign level_next = wbin_next - rbin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq1         <= '0;
            rq2         <= '0;
            wbin        <= '0;
            wptr_gray_q <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            wlevel_q    <= '0;
            wovf_q      <= 1'b0;
        end else begin
            rq1         <= bus.rptr_gray;
            rq2         <= rq1;
            wbin        <= wbin_next;
            wptr_gray_q <= wgray_next;
            wfull_q     <= wgray_next == full_cmp;
            wafull_q    <= level_next >= AF_LVL;
            wlevel_q    <= level_next;
            wovf_q      <= (bus.winc & wfull_q) | (wovf_q & ~bus.wovf_clr);
        end
    end

    assign bus.wen       = accept;
    assign bus.waddr     = wbin[ADDRSIZE-1:0];
    assign bus.wptr_gray = wptr_gray_q;
    assign bus.wfull     = wfull_q;
    assign bus.wafull    = wafull_q;
    assign bus.wlevel    = wlevel_q;
    assign bus.wovf      = wovf_q;

endmodule
